// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver.
// Deframes 5-8 data bits, optional parity, 1 or 2 stop bits, and buffers good
// characters in a small circular FIFO drained over a valid/ready handshake.
module uart_rx_core #(
  parameter int FIFO_AW = 2
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               cfg_rx_en,
  input  logic [1:0]         cfg_data_bits,
  input  logic               cfg_stop_bits,
  input  logic               cfg_pri_en,
  input  logic               cfg_pri_even,
  input  logic [11:0]        cfg_baud_div,
  input  logic               rxd,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   rx_fifo_cnt,
  output logic               rx_busy,
  output logic               err_parity,
  output logic               err_frame,
  output logic               err_overrun
);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state_reg, state_next;

  logic sync_reg, rxd_s;
  logic start_det, tick;
  logic [1:0] sh_data_bits;
  logic sh_stop2, sh_pri_en, sh_pri_even;
  logic [11:0] sh_baud_div, baud_cnt;
  logic [3:0] samp_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg, char_data;
  logic pe_reg, fe_reg, par_exp, last_data;
  logic start_smp, data_smp, par_smp, stop1_smp, stop2_smp;
  logic frame_done, fe_now, push_req, pop, full, empty, wr_en, overrun;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0] mem [DEPTH];
  logic err_parity_reg, err_frame_reg, err_overrun_reg;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge mclk) begin
    if (reset) begin
      sync_reg <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      sync_reg <= rxd;
      rxd_s    <= sync_reg;
    end
  end

  assign start_det = (state_reg == IDLE) && cfg_rx_en && !rxd_s;

  // Frame format is frozen at start detect so mid-frame cfg writes are harmless
  always_ff @(posedge mclk) begin
    if (reset) begin
      sh_data_bits <= 2'd0;
      sh_stop2     <= 1'b0;
      sh_pri_en    <= 1'b0;
      sh_pri_even  <= 1'b0;
      sh_baud_div  <= 12'd0;
    end else if (start_det) begin
      sh_data_bits <= cfg_data_bits;
      sh_stop2     <= cfg_stop_bits;
      sh_pri_en    <= cfg_pri_en;
      sh_pri_even  <= cfg_pri_even;
      sh_baud_div  <= cfg_baud_div;
    end
  end

  // Oversample tick divider, re-phased to the start edge
  always_ff @(posedge mclk) begin
    if (reset)
      baud_cnt <= 12'd0;
    else if (start_det)
      baud_cnt <= cfg_baud_div;
    else if (baud_cnt == 12'd0)
      baud_cnt <= sh_baud_div;
    else
      baud_cnt <= baud_cnt - 12'd1;
  end

  assign tick = (baud_cnt == 12'd0) && (state_reg != IDLE);

  // Tick count within a bit; cleared after the mid-start sample so every
  // later sample lands mid-bit when the count reaches 15
  always_ff @(posedge mclk) begin
    if (reset)
      samp_cnt <= 4'd0;
    else if (start_det || start_smp)
      samp_cnt <= 4'd0;
    else if (tick)
      samp_cnt <= samp_cnt + 4'd1;
  end

  assign last_data = (bit_cnt == ({1'b0, sh_data_bits} + 3'd4));
  assign char_data = shift_reg >> (2'd3 - sh_data_bits);
  assign par_exp   = (^char_data) ^ ~sh_pri_even;

  // Data shift register (LSB first, so data enters at the top) and error flags
  always_ff @(posedge mclk) begin
    if (reset || start_det) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      pe_reg    <= 1'b0;
      fe_reg    <= 1'b0;
    end else begin
      if (data_smp) begin
        shift_reg <= {rxd_s, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (par_smp && (rxd_s != par_exp))
        pe_reg <= 1'b1;
      if (stop1_smp && !rxd_s)
        fe_reg <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge mclk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM next-state logic; losing the enable aborts any frame in progress
  always_comb begin
    state_next = state_reg;
    if (!cfg_rx_en && state_reg != IDLE) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:   if (start_det) state_next = START;
        START:  if (start_smp) state_next = rxd_s ? IDLE : DATA;
        DATA:   if (data_smp && last_data) state_next = sh_pri_en ? PARITY : STOP1;
        PARITY: if (par_smp) state_next = STOP1;
        STOP1:  if (stop1_smp) state_next = sh_stop2 ? STOP2 : IDLE;
        STOP2:  if (stop2_smp) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: busy flag and the per-state mid-bit sample strobes
  always_comb begin
    rx_busy   = (state_reg != IDLE);
    start_smp = 1'b0;
    data_smp  = 1'b0;
    par_smp   = 1'b0;
    stop1_smp = 1'b0;
    stop2_smp = 1'b0;
    case (state_reg)
      START:  start_smp = tick && (samp_cnt == 4'd7);
      DATA:   data_smp  = tick && (samp_cnt == 4'd15);
      PARITY: par_smp   = tick && (samp_cnt == 4'd15);
      STOP1:  stop1_smp = tick && (samp_cnt == 4'd15);
      STOP2:  stop2_smp = tick && (samp_cnt == 4'd15);
      default: ;
    endcase
  end

  assign frame_done = cfg_rx_en && ((stop1_smp && !sh_stop2) || stop2_smp);
  assign fe_now     = fe_reg || ((stop1_smp || stop2_smp) && !rxd_s);
  assign push_req   = frame_done && !fe_now && !pe_reg;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop     = rx_valid && rx_ready;
  assign wr_en   = push_req && (!full || pop);
  assign overrun = push_req && full && !pop;

  // FIFO storage; a push into a full FIFO alongside a pop reuses the freed slot
  always_ff @(posedge mclk) begin
    if (wr_en)
      mem[wr_ptr[FIFO_AW-1:0]] <= char_data;
  end

  // FIFO pointers
  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Error pulses, aligned with the cycle a good character would appear
  always_ff @(posedge mclk) begin
    if (reset) begin
      err_parity_reg  <= 1'b0;
      err_frame_reg   <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      err_frame_reg   <= frame_done && fe_now;
      err_parity_reg  <= frame_done && !fe_now && pe_reg;
      err_overrun_reg <= overrun;
    end
  end

  assign rx_valid    = !empty;
  assign rx_data     = rx_valid ? mem[rd_ptr[FIFO_AW-1:0]] : 8'd0;
  assign rx_fifo_cnt = wr_ptr - rd_ptr;
  assign err_parity  = err_parity_reg;
  assign err_frame   = err_frame_reg;
  assign err_overrun = err_overrun_reg;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable UART receiver for the chip's UART peripheral, the device-side counterpart of the testbench UART agent's transmit path. It oversamples `rxd` at 16x the baud rate, deframes 5–8 data bits with optional parity and 1 or 2 stop bits, and flags parity, framing and overrun errors. Good characters are buffered in a small RX FIFO that the register block drains over a valid/ready handshake.

## Interface

**Parameters**
- `FIFO_AW`, default 2: FIFO address width; depth is `2**FIFO_AW` (4 entries by default).

**Ports**
- `mclk`, in, 1: core clock.
- `reset`, in, 1: synchronous, active-high reset. One clock; all state resets on `posedge mclk` while `reset`=1.
- `cfg_rx_en`, in, 1: receiver enable.
- `cfg_data_bits`, in, 2: data-bit count is value + 5 (0→5 … 3→8).
- `cfg_stop_bits`, in, 1: 0 = one stop bit, 1 = two stop bits.
- `cfg_pri_en`, in, 1: parity enable.
- `cfg_pri_even`, in, 1: 1 = even parity, 0 = odd parity.
- `cfg_baud_div`, in, 12: one oversample tick every `cfg_baud_div`+1 `mclk` cycles.
- `rxd`, in, 1: serial input, asynchronous, idle high.
- `rx_data`, out, 8: FIFO head; unused high bits are 0.
- `rx_valid`, out, 1: FIFO not empty.
- `rx_ready`, in, 1: pop request; a pop occurs when `rx_valid` & `rx_ready`.
- `rx_fifo_cnt`, out, `FIFO_AW`+1: FIFO occupancy.
- `rx_busy`, out, 1: FSM is not in IDLE.
- `err_parity`, out, 1: one-cycle pulse.
- `err_frame`, out, 1: one-cycle pulse.
- `err_overrun`, out, 1: one-cycle pulse.

## Operation

**Input synchronizer**
- `rxd` passes through a 2-flop synchronizer that resets to 1. Only the synchronized value `rxd_s` is used.

**Tick generator**
- `baud_cnt` counts down from `cfg_baud_div`; `tick` asserts when `baud_cnt`==0, and the counter then reloads.
- `baud_cnt` reloads on start detect, so phase is aligned to the start edge.
- A 4-bit `samp_cnt` counts ticks within a bit.

**FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE:** when `cfg_rx_en`=1 and `rxd_s`=0:
  - latch all `cfg_*` inputs into shadow registers;
  - clear `samp_cnt`;
  - go to START.
- **START:** on the 8th tick (mid-bit), sample `rxd_s`.
  - 1 → false start; return to IDLE with no error.
  - 0 → go to DATA.
- **DATA:** sample every 16th tick, LSB first, into the shift register.
  - After N bits, go to PARITY if parity is enabled, otherwise to STOP1.
- **PARITY:** sample on the 16th tick. Expected bit = XOR(data), inverted when `cfg_pri_even`=0. A mismatch sets the internal `pe` flag.
- **STOP1:** sample on the 16th tick; a 0 sets `fe`.
  - If two stop bits are configured, go to STOP2.
  - Otherwise finish the frame, then go to IDLE.
- **STOP2:** sample on the 16th tick; a 0 sets `fe`. Finish the frame, then go to IDLE.

**Frame completion**
- Completion happens at the mid-bit sample of the last stop bit, so the FSM is back in IDLE before the next start edge.
- `fe` set → pulse `err_frame`; discard the character.
- Otherwise `pe` set → pulse `err_parity`; discard the character.
- Otherwise push the character. If the FIFO is full and no pop happens in the same cycle, drop the character and pulse `err_overrun`.

**FIFO**
- Circular buffer with `FIFO_AW`+1-bit pointers; wrap-around is natural binary.
- Full: pointer MSBs differ and the low bits are equal. Empty: pointers are equal.
- Simultaneous push and pop when full: both occur, count is unchanged, no overrun.
- Simultaneous push and pop when empty: the push is accepted and the pop is ignored (`rx_valid` was 0).

**Boundary cases**
- `cfg_rx_en` deasserted mid-frame: abort to IDLE next cycle; no push, no error; FIFO contents retained.
- `cfg_*` changes mid-frame have no effect until the next start detect.
- `reset` mid-frame: FSM goes to IDLE and the FIFO is emptied.

## Timing

**Reset values**
- `rx_data`=0, `rx_valid`=0, `rx_fifo_cnt`=0, `rx_busy`=0, all `err_*`=0.
- Synchronizer flops = 1, FSM = IDLE.

**Definitions**
- D = `cfg_baud_div`+1 (mclk cycles per tick).
- N = data bits, P = parity bits (0/1), S = stop bits (1/2).

**Latency**
- Start detect: 2 cycles after the `rxd` falling edge (synchronizer).
- Last-stop sample: start detect + 8·D + 16·D·(N+P+S) cycles.
- Push is registered; `rx_valid`/`rx_data` update 1 cycle after the last-stop sample. Error pulses occur in that same cycle.

**Handshake**
- `rx_data` is stable while `rx_valid`=1 and no pop occurs.
- After a pop, the next entry (or `rx_valid`=0) is visible the following cycle.
- Full-throughput pops: one per cycle.

## Test plan

- **8N1, `cfg_baud_div`=7:** agent sends 0x55, 0xA3 → `rx_data` 0x55 then 0xA3, `rx_fifo_cnt` peaks at 2, no `err_*`.
- **7E2:** agent sends 0x41 (even parity, 2 stop bits) → `rx_data`=0x41. Repeat with a forced wrong parity bit → `err_parity` single pulse, `rx_fifo_cnt` stays 0.
- **Frame error:** agent sends a stop bit of 0 (stop-error mode) with 0x3C → `err_frame` pulse, nothing pushed. Next good char 0x12 → received correctly.
- **Overrun:** `rx_ready`=0, send 5 chars 0x01–0x05 → FIFO holds 0x01–0x04, `err_overrun` pulses once for 0x05. Then drain with `rx_ready`=1 → 0x01..0x04 on consecutive cycles, `rx_valid` drops after the 4th pop.
- **Glitch:** `rxd` low for 3·D cycles, then high → FSM returns to IDLE, no push, no error, `rx_busy` deasserts within 8·D+3 cycles.
- **Mid-frame abort:** `reset` asserted during DATA of 0x5A → all outputs at reset values next cycle. Then 5N1 char 0x15 → `rx_data`=0x15 with bits [7:5]=0.
